// File: rtl/procyon_rr_grant_ctrl.sv
// Round-robin grant controller sharing one single-ported resource among OPTN_NUM_REQ requesters.
// Latency: grant registered 1 cycle after request seen in IDLE; one mandatory IDLE bubble between grants.
// Backpressure: grant held until i_done, requester withdrawal, or optional hold-limit expiry.
module procyon_rr_grant_ctrl #(
  parameter int OPTN_NUM_REQ  = 4,
  parameter int OPTN_MAX_HOLD = 0,
  parameter int IDX_WIDTH     = (OPTN_NUM_REQ == 1) ? 1 : $clog2(OPTN_NUM_REQ),
  parameter int HOLD_WIDTH    = (OPTN_MAX_HOLD == 0) ? 1 : $clog2(OPTN_MAX_HOLD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPTN_NUM_REQ-1:0] i_req,
  input  logic                    i_done,
  output logic [OPTN_NUM_REQ-1:0] o_gnt,
  output logic [IDX_WIDTH-1:0]    o_gnt_idx,
  output logic                    o_gnt_valid,
  output logic                    o_timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OPTN_NUM_REQ - 1);

  state_t                  state;
  state_t                  state_next;
  logic [IDX_WIDTH-1:0]    ptr;
  logic [IDX_WIDTH-1:0]    ptr_next;
  logic [OPTN_NUM_REQ-1:0] gnt_next;
  logic [IDX_WIDTH-1:0]    gnt_idx_next;
  logic                    gnt_valid_next;
  logic                    timeout_next;

  logic                    sel_found;
  logic [IDX_WIDTH-1:0]    sel_idx;
  int                      cand;

  logic                    rel_abandon;
  logic                    rel_limit;
  logic                    release_now;

  // Release conditions while a grant is outstanding.
  assign rel_abandon = ~i_req[o_gnt_idx];
  assign release_now = (state == BUSY) && (i_done || rel_abandon || rel_limit);

  // Hold-limit counter exists only when a limit is configured.
  generate
    if (OPTN_MAX_HOLD == 0) begin : g_no_hold
      assign rel_limit = 1'b0;
    end else begin : g_hold
      localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(OPTN_MAX_HOLD - 1);
      logic [HOLD_WIDTH-1:0] hold_cnt;

      // Count cycles spent in BUSY without release; cleared while idle, saturating.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_cnt <= '0;
        end else if (state == IDLE) begin
          hold_cnt <= '0;
        end else if (!release_now && (hold_cnt != '1)) begin
          hold_cnt <= hold_cnt + HOLD_WIDTH'(1);
        end
      end

      assign rel_limit = (hold_cnt == HOLD_LAST);
    end
  endgenerate

  // Round-robin scan of the request vector starting at the priority pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 0; i < OPTN_NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % OPTN_NUM_REQ;
      if (!sel_found && i_req[IDX_WIDTH'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_WIDTH'(cand);
      end
    end
  end

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    gnt_next       = o_gnt;
    gnt_idx_next   = o_gnt_idx;
    gnt_valid_next = o_gnt_valid;
    timeout_next   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          gnt_next          = '0;
          gnt_next[sel_idx] = 1'b1;
          gnt_idx_next      = sel_idx;
          gnt_valid_next    = 1'b1;
          state_next        = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          gnt_next       = '0;
          gnt_valid_next = 1'b0;
          ptr_next       = (o_gnt_idx == LAST_IDX) ? '0 : (o_gnt_idx + IDX_WIDTH'(1));
          // A completion on the same edge as the limit is a normal finish, not a timeout.
          timeout_next   = rel_limit && !i_done;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      o_gnt       <= '0;
      o_gnt_idx   <= '0;
      o_gnt_valid <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      ptr         <= ptr_next;
      o_gnt       <= gnt_next;
      o_gnt_idx   <= gnt_idx_next;
      o_gnt_valid <= gnt_valid_next;
      o_timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_procyon_rr_grant_ctrl.sv
// Bench for the round-robin grant controller: directed scenarios plus randomized run vs reference model.
// Two instances: one with no hold limit, one with a hold limit of 5.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_procyon_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a = '0;
  logic       done_a = 1'b0;
  logic [3:0] req_b = '0;
  logic       done_b = 1'b0;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       to_a, to_b;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    bit busy;
    int idx;
    int ptr;
    int held;
    bit to;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  procyon_rr_grant_ctrl #(.OPTN_NUM_REQ(4), .OPTN_MAX_HOLD(0)) dut_a (
    .clk(clk), .rst(rst), .i_req(req_a), .i_done(done_a),
    .o_gnt(gnt_a), .o_gnt_idx(idx_a), .o_gnt_valid(vld_a), .o_timeout(to_a)
  );

  procyon_rr_grant_ctrl #(.OPTN_NUM_REQ(4), .OPTN_MAX_HOLD(5)) dut_b (
    .clk(clk), .rst(rst), .i_req(req_b), .i_done(done_b),
    .o_gnt(gnt_b), .o_gnt_idx(idx_b), .o_gnt_valid(vld_b), .o_timeout(to_b)
  );

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.busy = 0; m.idx = 0; m.ptr = 0; m.held = 0; m.to = 0;
    return m;
  endfunction

  // Reference: held counts the cycles the grant has been visible so far.
  function automatic mdl_t mdl_step(mdl_t m, logic [3:0] req, logic done, int hmax);
    mdl_t n;
    bit found;
    bit lim;
    n = m;
    n.to = 0;
    found = 0;
    if (!m.busy) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m.ptr + k) % 4;
        if (!found && req[c]) begin
          found = 1; n.busy = 1; n.idx = c; n.held = 1;
        end
      end
    end else begin
      lim = (hmax != 0) && (m.held == hmax);
      if (done || !req[m.idx] || lim) begin
        n.busy = 0;
        n.ptr  = (m.idx + 1) % 4;
        n.to   = lim && !done;
      end else begin
        n.held = m.held + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] mdl_out(mdl_t m);
    logic [3:0] g;
    g = m.busy ? (4'(1) << m.idx) : 4'b0000;
    return {g, 2'(m.idx), m.busy, m.to};
  endfunction

  task automatic tick();
    @(posedge clk);
    ma = mdl_step(ma, req_a, done_a, 0);
    mb = mdl_step(mb, req_b, done_b, 5);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = '0; done_a = 1'b0; req_b = '0; done_b = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if ({gnt_a, idx_a, vld_a, to_a} !== 8'h00) begin
      errors++; $display("FAIL reset_a: got %b want %b", {gnt_a, idx_a, vld_a, to_a}, 8'h00);
    end
    vectors++;
    if ({gnt_b, idx_b, vld_b, to_b} !== 8'h00) begin
      errors++; $display("FAIL reset_b: got %b want %b", {gnt_b, idx_b, vld_b, to_b}, 8'h00);
    end
    do_reset();
    tick();
    vectors++;
    if ({gnt_a, idx_a, vld_a, to_a} !== 8'h00) begin
      errors++; $display("FAIL idle_no_req: got %b want %b", {gnt_a, idx_a, vld_a, to_a}, 8'h00);
    end
  endtask

  task automatic test_single_done();
    do_reset();
    req_a = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({gnt_a, idx_a, vld_a, to_a} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
        errors++; $display("FAIL single_hold[%0d]: got %b want %b", k, {gnt_a, idx_a, vld_a, to_a}, {4'b0100, 2'd2, 1'b1, 1'b0});
      end
    end
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    vectors++;
    if ({gnt_a, idx_a, vld_a, to_a} !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_release: got %b want %b", {gnt_a, idx_a, vld_a, to_a}, {4'b0000, 2'd2, 1'b0, 1'b0});
    end
    req_a = 4'b1111;
    tick();
    vectors++;
    if ({gnt_a, idx_a, vld_a} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++; $display("FAIL single_ptr_next: got %b want %b", {gnt_a, idx_a, vld_a}, {4'b1000, 2'd3, 1'b1});
    end
  endtask

  task automatic test_rr_fairness();
    int         order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] one = 4'b0001;
    do_reset();
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({gnt_a, idx_a, vld_a} !== {one << order[k], 2'(order[k]), 1'b1}) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, {gnt_a, idx_a, vld_a}, {one << order[k], 2'(order[k]), 1'b1});
      end
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      vectors++;
      if ({gnt_a, vld_a} !== 5'b00000) begin
        errors++; $display("FAIL rr_bubble[%0d]: got %b want %b", k, {gnt_a, vld_a}, 5'b00000);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_a = 4'b1000;
    tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    req_a = 4'b1001;
    tick();
    vectors++;
    if ({gnt_a, idx_a} !== {4'b0001, 2'd0}) begin
      errors++; $display("FAIL wrap_first: got %b want %b", {gnt_a, idx_a}, {4'b0001, 2'd0});
    end
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    vectors++;
    if ({gnt_a, idx_a} !== {4'b1000, 2'd3}) begin
      errors++; $display("FAIL wrap_second: got %b want %b", {gnt_a, idx_a}, {4'b1000, 2'd3});
    end
  endtask

  task automatic test_abandon();
    do_reset();
    req_a = 4'b0010;
    tick();
    req_a = 4'b0000;
    tick();
    vectors++;
    if ({gnt_a, idx_a, vld_a, to_a} !== {4'b0000, 2'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL abandon_release: got %b want %b", {gnt_a, idx_a, vld_a, to_a}, {4'b0000, 2'd1, 1'b0, 1'b0});
    end
    req_a = 4'b1111;
    tick();
    vectors++;
    if ({gnt_a, idx_a} !== {4'b0100, 2'd2}) begin
      errors++; $display("FAIL abandon_ptr: got %b want %b", {gnt_a, idx_a}, {4'b0100, 2'd2});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      req_b = 4'b0010;
      for (int k = 0; k < 5; k++) begin
        tick();
        vectors++;
        if ({gnt_b, to_b} !== {4'b0010, 1'b0}) begin
          errors++; $display("FAIL timeout_hold[%0d/%0d]: got %b want %b", pass, k, {gnt_b, to_b}, {4'b0010, 1'b0});
        end
      end
      done_b = (pass == 1);
      tick();
      done_b = 1'b0;
      vectors++;
      if ({gnt_b, vld_b, to_b} !== {4'b0000, 1'b0, (pass == 0)}) begin
        errors++; $display("FAIL timeout_revoke[%0d]: got %b want %b", pass, {gnt_b, vld_b, to_b}, {4'b0000, 1'b0, (pass == 0)});
      end
      req_b = 4'b0000;
      tick();
      vectors++;
      if (to_b !== 1'b0) begin
        errors++; $display("FAIL timeout_pulse_width[%0d]: got %b want %b", pass, to_b, 1'b0);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_a = 4'b0100;
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({gnt_a, idx_a, vld_a, to_a} !== 8'h00) begin
      errors++; $display("FAIL reset_mid_grant: got %b want %b", {gnt_a, idx_a, vld_a, to_a}, 8'h00);
    end
    rst = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    req_a = 4'b1111;
    tick();
    vectors++;
    if ({gnt_a, idx_a, vld_a} !== {4'b0001, 2'd0, 1'b1}) begin
      errors++; $display("FAIL reset_first_grant: got %b want %b", {gnt_a, idx_a, vld_a}, {4'b0001, 2'd0, 1'b1});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) req_a[b] = ~req_a[b];
        if ($urandom_range(0, 11) == 0) req_b[b] = ~req_b[b];
      end
      done_a = ($urandom_range(0, 3) == 0);
      done_b = ($urandom_range(0, 9) == 0);
      tick();
      vectors++;
      if ({gnt_a, idx_a, vld_a, to_a} !== mdl_out(ma)) begin
        errors++; $display("FAIL random_a cyc %0d: got %b want %b", cyc, {gnt_a, idx_a, vld_a, to_a}, mdl_out(ma));
      end
      vectors++;
      if ({gnt_b, idx_b, vld_b, to_b} !== mdl_out(mb)) begin
        errors++; $display("FAIL random_b cyc %0d: got %b want %b", cyc, {gnt_b, idx_b, vld_b, to_b}, mdl_out(mb));
      end
    end
  endtask

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    test_reset();
    test_single_done();
    test_rr_fairness();
    test_wrap();
    test_abandon();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
